// File: rtl/reset_sequencer.sv
// Reset sequencer: stretches the block reset, holds every domain in reset for a fixed time,
// then releases the domains one at a time in index order, each gated by its ready acknowledge.
module reset_sequencer #(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           soft_req,
  input  logic [NUM_DOMAINS-1:0]         dom_ready,
  output logic [NUM_DOMAINS-1:0]         dom_reset,
  output logic                           all_ready,
  output logic                           busy,
  output logic                           timeout_err,
  output logic [$clog2(NUM_DOMAINS)-1:0] err_domain
);

  localparam int unsigned     IdxW       = $clog2(NUM_DOMAINS);
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(NUM_DOMAINS - 1);
  localparam logic [7:0]      HoldLast   = 8'(HOLD_CYCLES - 1);
  localparam logic [15:0]     TimeoutVal = 16'(TIMEOUT);

  typedef enum logic [2:0] {StAssert, StHold, StWait, StDone, StError} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d, idx_nxt;
  logic [7:0]             hold_cnt_q, hold_cnt_d;
  logic [15:0]            wait_cnt_q, wait_cnt_d, wait_inc;
  logic [NUM_DOMAINS-1:0] dom_reset_q, dom_reset_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [IdxW-1:0]        err_domain_q, err_domain_d;
  logic [SYNC_STAGES-1:0] rst_pipe;
  logic                   fsm_rst;

  // Ones drain out of the top of the pipe; a single-cycle reset still refills every stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      rst_pipe <= '1;
    end else begin
      rst_pipe <= rst_pipe << 1;
    end
  end

  // The raw reset is ORed in so domains go back into reset on the very edge it is sampled.
  assign fsm_rst = reset | rst_pipe[SYNC_STAGES-1];

  assign idx_nxt  = idx_q + IdxW'(1);
  assign wait_inc = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    hold_cnt_d    = hold_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    dom_reset_d   = dom_reset_q;
    timeout_err_d = timeout_err_q;
    err_domain_d  = err_domain_q;

    unique case (state_q)
      StAssert: begin
        dom_reset_d = '1;
        hold_cnt_d  = '0;
        state_d     = StHold;
      end

      StHold: begin
        dom_reset_d = '1;
        if (hold_cnt_q == HoldLast) begin
          idx_d          = '0;
          wait_cnt_d     = '0;
          dom_reset_d[0] = 1'b0;
          state_d        = StWait;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      StWait: begin
        // Ready is checked first so an acknowledge on the final count beats the timeout.
        if (dom_ready[idx_q]) begin
          wait_cnt_d = '0;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d                = idx_nxt;
            dom_reset_d[idx_nxt] = 1'b0;
          end
        end else if (wait_inc >= TimeoutVal) begin
          wait_cnt_d    = wait_inc;
          dom_reset_d   = '1;
          timeout_err_d = 1'b1;
          err_domain_d  = idx_q;
          state_d       = StError;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end

      StDone: begin
        dom_reset_d = '0;
        if (soft_req) begin
          dom_reset_d = '1;
          hold_cnt_d  = '0;
          state_d     = StHold;
        end
      end

      StError: begin
        dom_reset_d = '1;
        if (soft_req) begin
          hold_cnt_d    = '0;
          timeout_err_d = 1'b0;
          err_domain_d  = '0;
          state_d       = StHold;
        end
      end

      default: begin
        dom_reset_d = '1;
        state_d     = StAssert;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (fsm_rst) begin
      state_q       <= StAssert;
      idx_q         <= '0;
      hold_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      dom_reset_q   <= '1;
      timeout_err_q <= 1'b0;
      err_domain_q  <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      hold_cnt_q    <= hold_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      dom_reset_q   <= dom_reset_d;
      timeout_err_q <= timeout_err_d;
      err_domain_q  <= err_domain_d;
    end
  end

  assign dom_reset   = dom_reset_q;
  assign all_ready   = (state_q == StDone);
  assign busy        = (state_q != StDone) && (state_q != StError);
  assign timeout_err = timeout_err_q;
  assign err_domain  = err_domain_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed restart scenarios with randomized ready latencies,
// checked against a release-schedule model computed from per-domain latencies.
module tb_reset_sequencer;

  localparam int N  = 4;
  localparam int SS = 3;
  localparam int HC = 8;
  localparam int TO = 255;
  localparam int IW = $clog2(N);
  localparam int SW = N + 3 + IW;

  logic          clk;
  logic          reset;
  logic          soft_req;
  logic [N-1:0]  dom_ready;
  logic [N-1:0]  dom_reset;
  logic          all_ready;
  logic          busy;
  logic          timeout_err;
  logic [IW-1:0] err_domain;

  reset_sequencer #(
    .NUM_DOMAINS(N),
    .SYNC_STAGES(SS),
    .HOLD_CYCLES(HC),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .soft_req   (soft_req),
    .dom_ready  (dom_ready),
    .dom_reset  (dom_reset),
    .all_ready  (all_ready),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_domain (err_domain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;

  // Ready behaviour: domain d acknowledges lat[d] cycles after its reset falls.
  int lat[N];
  int low_cnt[N];
  bit noise;
  int ign_at   = -1;
  int dir_base = -1;

  // Model: predicted release edge per domain, plus done/error edges.
  int rel[N];
  int done_edge, err_edge, err_dom, end_edge;

  logic [N-1:0] dir_dr[6];
  logic         dir_ar[6];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at edge %0d", tag, obs, exp, edge_no);
    end
  endtask

  task automatic cycle();
    for (int d = 0; d < N; d++) begin
      if (dom_reset[d]) begin
        low_cnt[d]   = 0;
        dom_ready[d] = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      end else begin
        low_cnt[d]++;
        if (low_cnt[d] == lat[d]) dom_ready[d] = 1'b1;
        else if (low_cnt[d] > lat[d]) dom_ready[d] = noise ? 1'($urandom_range(0, 1)) : 1'b1;
        else dom_ready[d] = 1'b0;
      end
    end
    if (ign_at >= 0) soft_req = (edge_no + 1 == ign_at);
    @(posedge clk);
    edge_no++;
    @(negedge clk);
  endtask

  task automatic predict(input int first_rel);
    int t;
    t         = first_rel;
    done_edge = -1;
    err_edge  = -1;
    err_dom   = 0;
    for (int d = 0; d < N; d++) rel[d] = -1;
    for (int d = 0; d < N; d++) begin
      rel[d] = t;
      if (lat[d] > TO) begin
        err_edge = t + TO;
        err_dom  = d;
        break;
      end
      t += lat[d];
    end
    if (err_edge < 0) done_edge = t;
    end_edge = (err_edge >= 0) ? err_edge : done_edge;
  endtask

  function automatic logic [SW-1:0] expect_status(input int n);
    logic [N-1:0]  dr;
    logic          ar, bz, te;
    logic [IW-1:0] ed;
    dr = '1; ar = 1'b0; bz = 1'b1; te = 1'b0; ed = '0;
    if (err_edge >= 0 && n >= err_edge) begin
      bz = 1'b0; te = 1'b1; ed = IW'(err_dom);
    end else if (done_edge >= 0 && n >= done_edge) begin
      dr = '0; ar = 1'b1; bz = 1'b0;
    end else begin
      for (int d = 0; d < N; d++) if (rel[d] >= 0 && n >= rel[d]) dr[d] = 1'b0;
    end
    return {dr, ar, bz, te, ed};
  endfunction

  task automatic run_check(input string tag, input int stop_at);
    logic [SW-1:0] obs;
    for (int k = 0; k < 5000; k++) begin
      obs = {dom_reset, all_ready, busy, timeout_err, err_domain};
      check(tag, 64'(obs), 64'(expect_status(edge_no)));
      if (dir_base >= 0 && edge_no - dir_base >= 10 && edge_no - dir_base <= 15) begin
        check("dir_dom_reset", 64'(dom_reset), 64'(dir_dr[edge_no - dir_base - 10]));
        check("dir_all_ready", 64'(all_ready), 64'(dir_ar[edge_no - dir_base - 10]));
      end
      if (edge_no >= end_edge + 2 || edge_no >= stop_at) break;
      cycle();
    end
    ign_at = -1;
  endtask

  task automatic soft_restart(output int s);
    ign_at   = -1;
    soft_req = 1'b1;
    cycle();
    soft_req = 1'b0;
    s        = edge_no;
  endtask

  // Returns the first edge at which reset is sampled low.
  task automatic pulse_reset(input int n_cyc, output int z);
    reset = 1'b1;
    repeat (n_cyc) cycle();
    reset = 1'b0;
    z     = edge_no + 1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_dom_reset"}, 64'(dom_reset), 64'(4'b1111));
    check({tag, "_all_ready"}, 64'(all_ready), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(1));
    check({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
    check({tag, "_err_domain"}, 64'(err_domain), 64'(0));
  endtask

  task automatic random_lats();
    int r;
    for (int d = 0; d < N; d++) begin
      r = $urandom_range(0, 9);
      if (r == 0) lat[d] = TO + 1;
      else if (r == 1) lat[d] = TO;
      else lat[d] = $urandom_range(1, 12);
    end
  endtask

  initial begin
    int z, s;
    dir_dr = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000};
    dir_ar = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    reset = 1'b1; soft_req = 1'b0; dom_ready = '0; noise = 1'b0;
    for (int d = 0; d < N; d++) begin lat[d] = 1; low_cnt[d] = 0; end
    @(negedge clk);

    // Power-on sequence with each ready tied to its inverted reset.
    pulse_reset(3, z);
    check_reset_state("por");
    dir_base = z;
    predict(z + SS + HC);
    run_check("por_seq", 1 << 30);
    dir_base = -1;

    // Soft request in DONE, with an extra pulse during the run that must be ignored.
    noise = 1'b1;
    for (int d = 0; d < N; d++) lat[d] = $urandom_range(1, 12);
    soft_restart(s);
    check("soft_done_assert", 64'(dom_reset), 64'(4'b1111));
    predict(s + HC);
    ign_at = $urandom_range(s + 1, end_edge - 1);
    run_check("soft_done_seq", 1 << 30);

    // Reset in the middle of WAIT.
    for (int d = 0; d < N; d++) lat[d] = $urandom_range(1, 12);
    soft_restart(s);
    predict(s + HC);
    run_check("midwait_pre", rel[1] + 1);
    pulse_reset(1, z);
    check_reset_state("midwait_rst");
    predict(z + SS + HC);
    run_check("midwait_post", 1 << 30);

    // Domain 2 never acknowledges.
    lat = '{1, 1, TO + 1, 1};
    soft_restart(s);
    predict(s + HC);
    run_check("timeout_seq", 1 << 30);
    check("timeout_err_flag", 64'(timeout_err), 64'(1));
    check("timeout_err_domain", 64'(err_domain), 64'(2));
    check("timeout_dom_reset", 64'(dom_reset), 64'(4'b1111));
    check("timeout_busy", 64'(busy), 64'(0));

    // Soft request in ERROR; domain 1 acknowledges exactly on the final count.
    lat = '{1, TO, 1, 1};
    soft_restart(s);
    check("err_clear_flag", 64'(timeout_err), 64'(0));
    check("err_clear_domain", 64'(err_domain), 64'(0));
    check("err_clear_dom_reset", 64'(dom_reset), 64'(4'b1111));
    predict(s + HC);
    run_check("ready_wins_seq", 1 << 30);
    check("ready_wins_done", 64'(all_ready), 64'(1));
    check("ready_wins_no_err", 64'(timeout_err), 64'(0));

    // One-cycle reset while in DONE repeats the full latency.
    noise = 1'b0;
    for (int d = 0; d < N; d++) lat[d] = 1;
    pulse_reset(1, z);
    check_reset_state("done_rst");
    dir_base = z;
    predict(z + SS + HC);
    run_check("done_rst_seq", 1 << 30);
    dir_base = -1;

    // Randomized restarts from DONE or ERROR.
    noise = 1'b1;
    for (int it = 0; it < 6; it++) begin
      random_lats();
      soft_restart(s);
      check("rand_restart", 64'(dom_reset), 64'(4'b1111));
      predict(s + HC);
      ign_at = $urandom_range(s + 1, end_edge - 1);
      run_check("rand_seq", 1 << 30);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
